// File: rtl/sumador.sv
// Purpose: two-operand adder with button-driven entry. The parent owns the state register; this block returns next_st.
// Latency: operands are captured at the edge that sees a button rise; res follows the parent-registered state combinationally.
// Backpressure: none; a held button yields one rise only. The optional product display is enabled by SUMADOR_MULT_EN.
module sumador #(
   parameter int W_IN  = 3,
   parameter int W_OUT = 8   // must be >= 2*W_IN so the sum and product never overflow
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [W_IN-1:0]  num1,
   input  logic [W_IN-1:0]  num2,
   input  logic [1:0]       curr_st,
   input  logic             enter1,
   input  logic             enter2,
   output logic [W_OUT-1:0] res,
   output logic [1:0]       next_st
);

   typedef enum logic [1:0] {
      ST_ENTER_A = 2'b00,
      ST_ENTER_B = 2'b01,
      ST_SHOW    = 2'b10,
      ST_PRODUCT = 2'b11   // reachable only when the product feature is built in
   } state_t;

   logic [W_IN-1:0] a_reg;
   logic [W_IN-1:0] b_reg;
   logic            e1_q;
   logic            e2_q;
   logic            rise1;
   logic            rise2;
   logic            a_load;
   logic            b_load;

   // A button is acted on only at the cycle its level goes from low to high.
   assign rise1 = enter1 & ~e1_q;
   assign rise2 = enter2 & ~e2_q;

   // Edge-detector history and operand latches; reset discards any partial entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_reg <= '0;
         b_reg <= '0;
         e1_q  <= 1'b0;
         e2_q  <= 1'b0;
      end else begin
         e1_q <= enter1;
         e2_q <= enter2;
         if (a_load) a_reg <= num1;
         if (b_load) b_reg <= num2;
      end
   end

   // Next-state, operand-load strobes and display value from the parent's current state.
   always_comb begin
      next_st = curr_st;
      a_load  = 1'b0;
      b_load  = 1'b0;
      res     = '0;
      if (reset) begin
         next_st = ST_ENTER_A;
      end else begin
         case (curr_st)
            ST_ENTER_A: begin
               res = W_OUT'(num1);
               if (rise1) begin
                  a_load  = 1'b1;
                  next_st = ST_ENTER_B;
               end
            end
            ST_ENTER_B: begin
               res = W_OUT'(num2);
               if (rise2) begin
                  b_load  = 1'b1;
                  next_st = ST_SHOW;
               end
            end
            ST_SHOW: begin
               res = W_OUT'(a_reg) + W_OUT'(b_reg);
               // rise1 wins over rise2: starting a new entry takes priority.
               if (rise1) begin
                  a_load  = 1'b1;
                  next_st = ST_ENTER_B;
               end
`ifdef SUMADOR_MULT_EN
               else if (rise2) begin
                  next_st = ST_PRODUCT;
               end
`endif
            end
            default: begin
`ifdef SUMADOR_MULT_EN
               res = W_OUT'(a_reg) * W_OUT'(b_reg);
               if (rise1) begin
                  a_load  = 1'b1;
                  next_st = ST_ENTER_B;
               end else if (rise2) begin
                  next_st = ST_SHOW;
               end
`else
               // Illegal encoding without the product feature: recover to the start.
               next_st = ST_ENTER_A;
`endif
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sumador.sv
module tb_sumador;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] num1;
   logic [2:0] num2;
   logic [1:0] curr_st;
   logic       enter1;
   logic       enter2;
   logic [7:0] res;
   logic [1:0] next_st;

   logic [1:0] st_q = 2'b00;
   logic       force_st;
   logic [1:0] force_val;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // Parent-side state register, with an override to drive arbitrary encodings.
   always @(posedge clk) st_q <= next_st;
   assign curr_st = force_st ? force_val : st_q;

   sumador #(.W_IN(3), .W_OUT(8)) dut (
      .clk     (clk),
      .reset   (reset),
      .num1    (num1),
      .num2    (num2),
      .curr_st (curr_st),
      .enter1  (enter1),
      .enter2  (enter2),
      .res     (res),
      .next_st (next_st)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic press1(input logic [2:0] v);
      num1   = v;
      enter1 = 1'b1;
      tick();
      enter1 = 1'b0;
      tick();
   endtask

   task automatic press2(input logic [2:0] v);
      num2   = v;
      enter2 = 1'b1;
      tick();
      enter2 = 1'b0;
      tick();
   endtask

   initial begin
      reset = 1'b1; num1 = 3'd3; num2 = 3'd4; enter1 = 1'b0; enter2 = 1'b0;
      force_st = 1'b1; force_val = 2'b10;
      #2;
      chk("rst_next_from_show", {6'd0, next_st}, 8'h00);
      chk("rst_res_from_show", res, 8'h00);
      force_val = 2'b11;
      #1;
      chk("rst_next_from_11", {6'd0, next_st}, 8'h00);
      tick();
      tick();
      force_st = 1'b0;
      reset = 1'b0;
      #1;
      chk("post_rst_state", {6'd0, curr_st}, 8'h00);
      chk("post_rst_echo_a", res, 8'h03);
      force_st = 1'b1; force_val = 2'b10;
      #1;
      chk("post_rst_regs_zero", res, 8'h00);
      force_st = 1'b0;

      // Normal add 5 + 6
      num1 = 3'd5; enter1 = 1'b1;
      #1;
      chk("a_next_on_rise", {6'd0, next_st}, 8'h01);
      tick();
      enter1 = 1'b0;
      #1;
      chk("state_enter_b", {6'd0, curr_st}, 8'h01);
      chk("echo_b", res, 8'h04);
      tick();
      press2(3'd6);
      #1;
      chk("state_show", {6'd0, curr_st}, 8'h02);
      chk("sum_5_6", res, 8'h0B);
      tick();
      chk("show_holds", {6'd0, curr_st}, 8'h02);

      // Maximum 7 + 7 via restart from SHOW
      press1(3'd7);
      press2(3'd7);
      #1;
      chk("sum_7_7", res, 8'h0E);

      // Held button: one transition only
      reset = 1'b1; tick(); reset = 1'b0;
      num1 = 3'd1; num2 = 3'd2; enter1 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         #1;
         chk("held_enter1_state", {6'd0, curr_st}, 8'h01);
      end
      enter1 = 1'b0;
      tick();

      // Wrong button in ENTER_B
      num2 = 3'd3;
      press1(3'd6);
      #1;
      chk("wrong_btn_b_state", {6'd0, curr_st}, 8'h01);
      chk("wrong_btn_b_echo", res, 8'h03);

      // Wrong button in ENTER_A
      reset = 1'b1; tick(); reset = 1'b0;
      num1 = 3'd4; enter2 = 1'b1;
      #1;
      chk("wrong_btn_a_next", {6'd0, next_st}, 8'h00);
      tick();
      enter2 = 1'b0;
      #1;
      chk("wrong_btn_a_state", {6'd0, curr_st}, 8'h00);
      chk("wrong_btn_a_echo", res, 8'h04);
      tick();

      // Restart from SHOW keeps old B until overwritten
      press1(3'd1);
      press2(3'd2);
      #1;
      chk("sum_1_2", res, 8'h03);
      press1(3'd2);
      #1;
      chk("restart_state", {6'd0, curr_st}, 8'h01);
      force_st = 1'b1; force_val = 2'b10;
      #1;
      chk("restart_a2_b2", res, 8'h04);
      force_st = 1'b0;

      // Reset mid-entry
      reset = 1'b1;
      #1;
      chk("mid_rst_next", {6'd0, next_st}, 8'h00);
      chk("mid_rst_res", res, 8'h00);
      tick();
      reset = 1'b0;
      #1;
      chk("mid_rst_state", {6'd0, curr_st}, 8'h00);
      force_st = 1'b1; force_val = 2'b10;
      #1;
      chk("mid_rst_discard", res, 8'h00);
      force_st = 1'b0;

      // Both buttons rising in SHOW: rise1 wins
      press1(3'd3);
      press2(3'd4);
      #1;
      chk("sum_3_4", res, 8'h07);
      num1 = 3'd5; enter1 = 1'b1; enter2 = 1'b1;
      #1;
      chk("both_rise_next", {6'd0, next_st}, 8'h01);
      tick();
      enter1 = 1'b0; enter2 = 1'b0;
      tick();
      force_st = 1'b1; force_val = 2'b10;
      #1;
      chk("both_rise_a5_b4", res, 8'h09);
      force_st = 1'b0;
      press2(3'd7);
      press1(3'd7);
      press2(3'd7);
      #1;
      chk("show_7_7", res, 8'h0E);

`ifdef SUMADOR_MULT_EN
      press2(3'd0);
      #1;
      chk("prod_state", {6'd0, curr_st}, 8'h03);
      chk("prod_7_7", res, 8'h31);
      press2(3'd0);
      #1;
      chk("prod_back_show", {6'd0, curr_st}, 8'h02);
      chk("prod_back_sum", res, 8'h0E);
      press2(3'd0);
      press1(3'd3);
      #1;
      chk("prod_rise1_state", {6'd0, curr_st}, 8'h01);
      press2(3'd2);
      #1;
      chk("prod_rise1_sum", res, 8'h05);
`else
      press2(3'd0);
      #1;
      chk("no_mult_show_holds", {6'd0, curr_st}, 8'h02);
      chk("no_mult_sum", res, 8'h0E);
      force_st = 1'b1; force_val = 2'b11;
      #1;
      chk("illegal_next", {6'd0, next_st}, 8'h00);
      chk("illegal_res", res, 8'h00);
      force_st = 1'b0;
`endif

      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sumador.md
Name: sumador

Overview:
- Two-operand 3-bit adder with a button-driven entry sequence: operand A on enter1, operand B on enter2, then the 8-bit zero-extended sum is shown.
- The state register lives in the parent. This block receives the current state (curr_st) and returns the combinational next state (next_st), which the parent registers on posedge clk.
- Operand latches and button edge detectors are held internally.

Parameters:
- W_IN, 3, operand width.
- W_OUT, 8, result width; must satisfy W_OUT >= 2*W_IN.

Ports:
- clk  input  1  system clock; all internal registers update on its rising edge.
- reset  input  1  synchronous, active-high reset.
- num1  input  3  operand A input (switches).
- num2  input  3  operand B input (switches).
- curr_st  input  2  current state, driven by the parent's register.
- enter1  input  1  level from button 1; acted on at its rising edge.
- enter2  input  1  level from button 2; acted on at its rising edge.
- res  output  8  display value.
- next_st  output  2  combinational next state, registered by the parent.

Behaviour:
- States (curr_st encoding):
  - 00 ENTER_A
  - 01 ENTER_B
  - 10 SHOW
  - 11 PRODUCT (only with the optional feature; otherwise illegal)
- Edge detect: e1_q/e2_q are registered copies of enter1/enter2. rise1 = enter1 & ~e1_q; rise2 = enter2 & ~e2_q.
  - A button held high produces exactly one rise.
  - e*_q clear to 0 on reset.
- Internal registers: a_reg[2:0], b_reg[2:0], e1_q, e2_q. All clear to 0 on reset (synchronous).
- While reset=1: next_st=00 and res=0 (combinational). The parent's register becomes 00 at the same edge that clears the internals.
- Transitions (reset=0):
  - ENTER_A: rise1 -> a_reg<=num1 at this edge, next_st=01. Otherwise stay 00. rise2 ignored.
  - ENTER_B: rise2 -> b_reg<=num2, next_st=10. Otherwise stay 01. rise1 ignored.
  - SHOW: rise1 -> a_reg<=num1, next_st=01 (starts a new entry; b_reg keeps its old value until overwritten). Otherwise stay 10.
  - 11 without the feature: next_st=00, no register writes.
  - rise1 and rise2 in the same cycle: only the transition defined for the current state fires; rise1 has priority in SHOW.
- res (combinational from curr_st and registers):
  - ENTER_A: {5'b0,num1} (live echo).
  - ENTER_B: {5'b0,num2} (live echo).
  - SHOW: {5'b0,a_reg} + {5'b0,b_reg}, computed at 8 bits; maximum 14, no overflow possible.
  - 11 without the feature: 0.
- Latency:
  - Operand capture occurs at the clock edge that sees the rise.
  - res reflects the new state in the cycle after the parent registers next_st.
- Reset mid-entry: any stored operands are discarded; the sequence restarts in ENTER_A.

Optional Feature:
- Macro SUMADOR_MULT_EN.
- Defined:
  - In SHOW, rise2 (with no rise1) -> next_st=11.
  - In PRODUCT: res = a_reg*b_reg at 8 bits (maximum 49).
  - In PRODUCT: rise2 -> next_st=10.
  - In PRODUCT: rise1 -> a_reg<=num1, next_st=01.
  - Otherwise PRODUCT holds at 11.
- Undefined:
  - rise2 is ignored in SHOW.
  - State 11 is illegal: next_st=00, res=0.
  - No multiplier is synthesised.

Test Plan:
- Reset: hold reset 2 cycles from arbitrary curr_st -> next_st=00, res=0; a_reg=b_reg=0 afterwards.
- Normal add: num1=5, pulse enter1 -> state 01. num2=6, pulse enter2 -> state 10, res=0x0B. Maximum case 7+7 -> res=0x0E.
- Held button: hold enter1 high for 5 cycles in ENTER_A -> exactly one transition to 01. The held enter1 does not advance ENTER_B.
- Wrong button: enter2 pulsed in ENTER_A and enter1 pulsed in ENTER_B -> state unchanged; res echoes num1 or num2 respectively.
- Restart and mid-entry reset:
  - In SHOW, num1=2, pulse enter1 -> state 01 with a_reg=2.
  - Reset asserted in ENTER_B -> state 00, res=0.
- With SUMADOR_MULT_EN: A=7, B=7 in SHOW, pulse enter2 -> state 11, res=0x31. Pulse enter2 again -> state 10, res=0x0E. Without the macro, forcing curr_st=11 -> next_st=00, res=0.
